// File: rtl/prod_accum_pkg.sv
// Shared types and default widths for the product accumulator.
// Frame FSM states and width constants live here.
package prod_accum_pkg;

    localparam int ACC_W_DEF = 40;
    localparam int LEN_W_DEF = 8;
    localparam int PROD_W    = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/prod_accum_add.sv
// Accumulator adder with carry-out and optional clamp.
// Macro PROD_ACCUM_SAT_EN: clamp to all-ones on carry, else wrap.
module prod_accum_add
    import prod_accum_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  a,
    input  logic [PROD_W-1:0] b,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

    logic [ACC_W:0] wide;

    // Widened add; the clamp keeps a saturated total pinned at all-ones.
    always_comb begin
        wide  = {1'b0, a} + {{(ACC_W + 1 - PROD_W){1'b0}}, b};
        carry = wide[ACC_W];
`ifdef PROD_ACCUM_SAT_EN
        sum = carry ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
`else
        sum = wide[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/prod_accum.sv
// Frame accumulator: sums cfg_len products, then holds the result.
// Macro PROD_ACCUM_SAT_EN selects saturating accumulation.
module prod_accum
    import prod_accum_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf
);

    localparam logic [LEN_W:0] ONE  = {{LEN_W{1'b0}}, 1'b1};
    localparam logic [LEN_W:0] FULL = {1'b1, {LEN_W{1'b0}}};

    state_t           state;
    state_t           state_nx;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] add_a;
    logic [ACC_W-1:0] add_sum;
    logic             carry;
    logic             ovf;
    logic             rdy;
    logic             accept;
    logic [LEN_W:0]   cnt;
    logic [LEN_W:0]   cnt_inc;
    logic [LEN_W:0]   len_q;
    logic [LEN_W:0]   len_in;

    // A zero length field encodes the full 2^LEN_W frame.
    assign len_in  = (cfg_len == '0) ? FULL : {1'b0, cfg_len};
    assign cnt_inc = cnt + ONE;

    assign in_ready  = rdy & (state != HOLD);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == HOLD);
    assign out_sum   = acc;
    assign out_ovf   = ovf;

    // The first product of a frame is added to zero, i.e. loaded.
    assign add_a = (state == IDLE) ? '0 : acc;

    prod_accum_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .a     (add_a),
        .b     (in_prod),
        .sum   (add_sum),
        .carry (carry)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: frame start, last product, result handoff.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = (len_in == ONE) ? HOLD : ACC;
                end
            end
            ACC: begin
                if (accept && (cnt_inc == len_q)) begin
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: accumulate, count, sticky overflow; ready after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            cnt   <= '0;
            len_q <= '0;
            ovf   <= 1'b0;
            rdy   <= 1'b0;
        end else begin
            rdy <= 1'b1;
            if (accept) begin
                acc <= add_sum;
                if (state == IDLE) begin
                    len_q <= len_in;
                    cnt   <= ONE;
                    ovf   <= carry;
                end else begin
                    cnt <= cnt_inc;
                    ovf <= ovf | carry;
                end
            end
        end
    end

endmodule

// File: doc/prod_accum.md
PROD_ACCUM -- requirements
Module: prod_accum

Interface
REQ-001 SHALL have parameter ACC_W, default 40, giving the accumulator and result width in bits (legal range 33..64).
REQ-002 SHALL have parameter LEN_W, default 8, giving the frame-length field width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port cfg_len, input, LEN_W bits: products per frame; the value 0 means 2^LEN_W.
REQ-006 SHALL have port in_valid, input, 1 bit: in_prod is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block can accept a product.
REQ-008 SHALL have port in_prod, input, 32 bits: unsigned product from the upstream approximate 16x16 multiplier.
REQ-009 SHALL have port out_valid, output, 1 bit: the frame result is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 SHALL have port out_sum, output, ACC_W bits: the frame sum.
REQ-012 SHALL have port out_ovf, output, 1 bit: the frame sum exceeded 2^ACC_W-1.

Function
REQ-013 SHALL use an FSM with states IDLE, ACC and HOLD.
REQ-014 SHALL accept a product in a cycle where in_valid and in_ready are both 1.
REQ-015 SHALL drive in_ready=1 in IDLE and ACC, and in_ready=0 in HOLD.
REQ-016 SHALL, on a product accepted in IDLE, latch cfg_len as the frame length, load acc=in_prod zero-extended to ACC_W, load cnt=1, and go to ACC; if the length is 1, it SHALL go directly to HOLD instead.
REQ-017 SHALL ignore changes to cfg_len after it is latched, until the next frame starts.
REQ-018 SHALL, on a product accepted in ACC, set acc=acc+in_prod and cnt=cnt+1; when cnt reaches the latched length, it SHALL go to HOLD.
REQ-019 SHALL set out_valid=1 in the cycle after the last product of a frame is accepted (1-cycle latency).
REQ-020 SHALL keep out_sum and out_ovf stable while out_valid=1.
REQ-021 SHALL, when out_valid and out_ready are both 1, clear out_valid and move to IDLE at that edge; in_ready SHALL rise on the next cycle (no same-cycle bypass).
REQ-022 SHALL, on a carry out of bit ACC_W-1 at any add in the frame, set a sticky ovf flag; ovf SHALL be cleared at the start of each frame.
REQ-023 SHALL hold state unchanged in IDLE or ACC while in_valid=0 (bubbles allowed).
REQ-024 SHALL never present out_valid=1 in IDLE or ACC.

Reset
REQ-025 SHALL, while rst_n=0, force state=IDLE, acc=0, cnt=0, ovf=0, out_valid=0, out_sum=0, out_ovf=0 and in_ready=0.
REQ-026 SHALL drive in_ready=1 from the first clock edge after reset deassertion.
REQ-027 SHALL discard any partial frame or pending result when reset is asserted mid-operation; no result from that frame is emitted.

Configuration
REQ-028 SHALL provide macro PROD_ACCUM_SAT_EN to select saturating accumulation.
REQ-029 SHALL, with PROD_ACCUM_SAT_EN defined, clamp acc to 2^ACC_W-1 on overflow and hold it there for the rest of the frame; out_ovf is still reported.
REQ-030 SHALL, without PROD_ACCUM_SAT_EN, let acc wrap modulo 2^ACC_W; out_ovf is still reported.

Structure
REQ-031 SHALL place the state enum (IDLE/ACC/HOLD) and the default width constants in the package prod_accum_pkg.
REQ-032 SHALL implement the adder with carry-out and optional clamp as the sub-module prod_accum_add; the FSM, counter and handshake stay in prod_accum.

Verification
REQ-033 SHALL cover: cfg_len=4, products 100,200,300,400 back-to-back -> out_valid one cycle after the 4th accept, out_sum=1000, out_ovf=0.
REQ-034 SHALL cover: cfg_len=1, in_prod=0xFFFE0000 -> HOLD directly, out_sum=0xFFFE0000, in_ready=0 until the result is taken.
REQ-035 SHALL cover: ACC_W=33, cfg_len=3, three products of 0xFFFFFFFF -> out_ovf=1; out_sum=0x1FFFFFFFF with PROD_ACCUM_SAT_EN, and 0x0FFFFFFFD without it.
REQ-036 SHALL cover: out_ready held at 0 for 5 cycles with in_valid=1 -> in_ready=0 and out_sum stable throughout; once out_ready=1, out_valid drops and in_ready=1 the following cycle.
REQ-037 SHALL cover: rst_n pulsed low after 2 of 4 products -> out_valid=0; a subsequent fresh 4-product frame sums correctly with no carry-over.
REQ-038 SHALL cover: cfg_len=0 with LEN_W=8 -> 256 products of 1 give out_sum=256; cfg_len changed mid-frame has no effect.
